// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M execute unit: 32-cycle shift-add multiply / restoring divide
// that stalls the pipeline while busy and emits a one-cycle result strobe.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUop_EX,
  input  logic [6:0]      FUNCT7_EX,
  input  logic [2:0]      FUNCT3_EX,
  input  logic [4:0]      RD_EX,
  input  logic [XLEN-1:0] OP_A_EX,
  input  logic [XLEN-1:0] OP_B_EX,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic [4:0]      result_rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              neg_r;

  logic            m_req;
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign m_req  = (ALUop_EX == 2'b10) && (FUNCT7_EX == 7'b0000001);
  assign sgn_a  = FUNCT3_EX inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign sgn_b  = FUNCT3_EX inside {3'b001, 3'b100, 3'b110};
  assign neg_a  = sgn_a && OP_A_EX[XLEN-1];
  assign neg_b  = sgn_b && OP_B_EX[XLEN-1];
  assign mag_a  = neg_a ? -OP_A_EX : OP_A_EX;
  assign mag_b  = neg_b ? -OP_B_EX : OP_B_EX;
  assign is_div = FUNCT3_EX[2];

  assign div_zero = is_div && (OP_B_EX == '0);
  assign div_ovf  = is_div && !FUNCT3_EX[0] && (OP_A_EX == INT_MIN) && (OP_B_EX == '1);
  // FUNCT3[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (FUNCT3_EX[1] ? OP_A_EX : '1)
                                : (FUNCT3_EX[1] ? '0 : INT_MIN);

  // Multiply: acc = {partial product high, remaining multiplier bits}, shifted right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per step.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;
  assign prod    = neg_q ? -acc : acc;
  assign quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = !op[2] ? ((op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                          : (op[1] ? rem : quo);

  assign stall = reset && !flush &&
                 (((state == IDLE) && m_req) || (state == BUSY) || (state == FIX));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      op           <= '0;
      rd_q         <= '0;
      operand      <= '0;
      acc          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_rd    <= '0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (m_req) begin
              op    <= FUNCT3_EX;
              rd_q  <= RD_EX;
              count <= '0;
              neg_q <= neg_a ^ neg_b;
              neg_r <= neg_a;
              if (div_zero || div_ovf) begin
                result       <= special_res;
                result_rd    <= RD_EX;
                result_valid <= 1'b1;
                state        <= DONE;
              end else begin
                operand <= is_div ? mag_b : mag_a;
                acc     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                state   <= BUSY;
              end
            end
          end
          BUSY: begin
            acc   <= op[2] ? div_next : mul_next;
            count <= count + CW'(1);
            if (count == LAST) state <= FIX;
          end
          FIX: begin
            result       <= fix_res;
            result_rd    <= rd_q;
            result_valid <= 1'b1;
            state        <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an ID/EX-style driver that holds each
// op while stall is high, and a per-cycle comparison against a behavioural model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUop_EX;
  logic [6:0]  FUNCT7_EX;
  logic [2:0]  FUNCT3_EX;
  logic [4:0]  RD_EX;
  logic [31:0] OP_A_EX, OP_B_EX;
  logic        flush;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  result_rd;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ALUop_EX(ALUop_EX), .FUNCT7_EX(FUNCT7_EX),
    .FUNCT3_EX(FUNCT3_EX), .RD_EX(RD_EX), .OP_A_EX(OP_A_EX), .OP_B_EX(OP_B_EX),
    .flush(flush), .stall(stall), .result(result), .result_valid(result_valid),
    .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M semantics computed with plain 64-bit / integer arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    int sa, sb, q;
    bit ovf;
    sa = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model_res = 32'h0;
    case (f3)
      3'd0: begin p = {32'h0, a} * {32'h0, b};             model_res = p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model_res = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};       model_res = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b};             model_res = p[63:32]; end
      3'd4: if (b == 0) model_res = 32'hFFFF_FFFF;
            else if (ovf) model_res = a;
            else begin q = sa / sb; model_res = q; end
      3'd5: model_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) model_res = a;
            else if (ovf) model_res = 32'h0;
            else begin q = sa % sb; model_res = q; end
      default: model_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle (1 = cycle the op is first presented) on which result_valid must rise.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    bit special;
    special = f3[2] && ((b == 0) ||
              (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    model_lat = special ? 2 : 35;
  endfunction

  // Model state for the op currently held in the ID/EX register.
  bit          check_en = 0;
  bit          op_is_m  = 0;
  int          op_age   = 0;
  int          op_lat   = 1;
  logic [31:0] op_res   = '0;
  logic [4:0]  op_rd    = '0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  always @(negedge clk) begin
    if (check_en) begin
      bit exp_stall, exp_valid;
      exp_stall = op_is_m && (op_age < op_lat);
      exp_valid = op_is_m && (op_age == op_lat);
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("result_valid", {31'b0, result_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        check("result", result, op_res);
        check("result_rd", {27'b0, result_rd}, {27'b0, op_rd});
        last_res = op_res;
        last_rd  = op_rd;
      end else if (!op_is_m) begin
        check("result_hold", result, last_res);
        check("result_rd_hold", {27'b0, result_rd}, {27'b0, last_rd});
      end
    end
  end

  task automatic drive(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    ALUop_EX = aluop; FUNCT7_EX = f7; FUNCT3_EX = f3; RD_EX = rd; OP_A_EX = a; OP_B_EX = b;
  endtask

  // Present one op on the edge after the previous op left, hold it until it advances.
  task automatic run_op(input bit is_m, input logic [1:0] aluop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    if (is_m) drive(2'b10, 7'b0000001, f3, rd, a, b);
    else      drive(aluop, f7, f3, rd, a, b);
    op_is_m  = is_m;
    op_lat   = is_m ? model_lat(f3, a, b) : 1;
    op_res   = model_res(f3, a, b);
    op_rd    = rd;
    op_age   = 1;
    check_en = 1;
    while (op_age < op_lat) begin
      @(posedge clk); #1;
      op_age++;
    end
  endtask

  task automatic run_m(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    run_op(1'b1, 2'b10, 7'b0000001, f3, rd, a, b);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: pick_operand = 32'h0;
      1: pick_operand = 32'hFFFF_FFFF;
      2: pick_operand = 32'h8000_0000;
      3: pick_operand = $urandom_range(0, 20);
      default: pick_operand = $urandom;
    endcase
  endfunction

  task automatic idle_checks(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({name, "_stall"}, {31'b0, stall}, 32'h0);
      check({name, "_valid"}, {31'b0, result_valid}, 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(2'b10, 7'b0000001, 3'd0, 5'd9, 32'd3, 32'd4);
    #3;
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_valid", {31'b0, result_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_rd", {27'b0, result_rd}, 32'h0);
    drive(2'b00, 7'b0, 3'd0, 5'd0, 32'h0, 32'h0);

    // Hand-computed values that pin the reference model.
    check("pin_mul",      model_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulh",     model_res(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mulhu",    model_res(3'd3, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mulhsu",   model_res(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("pin_div",      model_res(3'd4, -32'sd7, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem",      model_res(3'd6, -32'sd7, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu",     model_res(3'd5, 32'd100, 32'd7), 32'd14);
    check("pin_remu",     model_res(3'd7, 32'd100, 32'd7), 32'd2);
    check("pin_div0",     model_res(3'd4, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_rem0",     model_res(3'd6, 32'd5, 32'd0), 32'd5);
    check("pin_divovf",   model_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_removf",   model_res(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    check("pin_lat_norm", model_lat(3'd0, 32'd7, 32'hFFFF_FFFD), 32'd35);
    check("pin_lat_spec", model_lat(3'd4, 32'd5, 32'd0), 32'd2);

    #9 reset = 1'b1;

    // Directed vectors, including back-to-back MULs and a plain ADD.
    run_m(3'd0, 5'd1,  32'd7, 32'hFFFF_FFFD);
    run_m(3'd1, 5'd2,  32'h8000_0000, 32'h8000_0000);
    run_m(3'd3, 5'd3,  32'h8000_0000, 32'h8000_0000);
    run_m(3'd2, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_m(3'd4, 5'd5,  -32'sd7, 32'd2);
    run_m(3'd6, 5'd6,  -32'sd7, 32'd2);
    run_m(3'd5, 5'd7,  32'd100, 32'd7);
    run_m(3'd7, 5'd8,  32'd100, 32'd7);
    run_m(3'd4, 5'd9,  32'd5, 32'd0);
    run_m(3'd6, 5'd10, 32'd5, 32'd0);
    run_m(3'd4, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_m(3'd6, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    run_m(3'd0, 5'd13, 32'd3, 32'd4);
    run_m(3'd0, 5'd14, 32'd5, 32'd6);
    run_op(1'b0, 2'b10, 7'b0000000, 3'd0, 5'd15, 32'd1, 32'd2);
    run_op(1'b0, 2'b00, 7'b0000001, 3'd4, 5'd16, 32'd1, 32'd0);

    // Flush during BUSY (count=10 is the 12th cycle of the op).
    check_en = 0;
    @(posedge clk); #1;
    drive(2'b10, 7'b0000001, 3'd5, 5'd17, 32'd1000, 32'd3);
    for (int i = 1; i < 12; i++) begin @(posedge clk); #1; end
    check("pre_flush_stall", {31'b0, stall}, 32'h1);
    flush = 1'b1;
    #1 check("flush_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(2'b00, 7'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    idle_checks("after_flush", 40);
    check("flush_result_hold", result, last_res);

    // Flush in the same cycle as a start: the op must not begin.
    @(posedge clk); #1;
    drive(2'b10, 7'b0000001, 3'd0, 5'd18, 32'd9, 32'd9);
    flush = 1'b1;
    #1 check("flush_start_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(2'b00, 7'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    idle_checks("flush_start", 40);

    // Unit must be back in IDLE and accept a normal op.
    run_m(3'd0, 5'd19, 32'd3, 32'd4);

    // Reset mid-divide at count=20 (22nd cycle of the op).
    check_en = 0;
    @(posedge clk); #1;
    drive(2'b10, 7'b0000001, 3'd5, 5'd20, 32'd500, 32'd7);
    for (int i = 1; i < 22; i++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midreset_stall", {31'b0, stall}, 32'h0);
    check("midreset_valid", {31'b0, result_valid}, 32'h0);
    check("midreset_result", result, 32'h0);
    check("midreset_rd", {27'b0, result_rd}, 32'h0);
    last_res = '0;
    last_rd  = '0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    drive(2'b00, 7'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    idle_checks("post_reset", 40);

    // Randomized mix of M and non-M ops.
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 99) < 85) begin
        run_m(f3, rd, a, b);
      end else begin
        logic [1:0] aluop;
        logic [6:0] f7;
        aluop = 2'($urandom_range(0, 3));
        f7    = (aluop == 2'b10) ? (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20)
                                 : 7'($urandom_range(0, 127));
        run_op(1'b0, aluop, f7, f3, rd, a, b);
      end
    end
    run_op(1'b0, 2'b00, 7'b0, 3'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    check_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs; executes RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively.
- Selects M-type ops from ALUop_EX, FUNCT7_EX and FUNCT3_EX.
- Holds the pipeline via stall while busy, then presents one result cycle to the EX result mux together with the destination register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 = reset
- ALUop_EX  input  2  ALU op class from the ID/EX register; 2'b10 = R-type
- FUNCT7_EX  input  7  funct7 from the ID/EX register; 7'b0000001 = M extension
- FUNCT3_EX  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- RD_EX  input  5  destination register from the ID/EX register
- OP_A_EX  input  32  rs1 operand, after forwarding
- OP_B_EX  input  32  rs2 operand, after forwarding
- flush  input  1  kills any in-flight op (branch redirect)
- stall  output  1  holds PC, IF/ID and ID/EX while high
- result  output  32  M-op result, valid when result_valid=1
- result_valid  output  1  one-cycle strobe; EX mux selects result
- result_rd  output  5  destination register for result

Behaviour:
- States: IDLE, BUSY, FIX, DONE.
- m_req = (ALUop_EX==2'b10) && (FUNCT7_EX==7'b0000001).
- Reset (reset=0, asynchronous) forces state=IDLE and clears all registers: result=0, result_valid=0, result_rd=0, count=0. stall is combinational and reads 0 in reset.
- stall = m_req in IDLE (same cycle as detection), 1 in BUSY and FIX, 0 in DONE.
- IDLE, m_req=1, flush=0:
  - Latch FUNCT3, RD_EX, operand magnitudes and the result sign.
  - Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed, B as unsigned. All other ops are unsigned.
  - Go to BUSY with count=0.
- Special cases bypass BUSY and go IDLE to DONE:
  - Divide by zero: quotient = 32'hFFFFFFFF, remainder = OP_A.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF, DIV/REM): quotient = 32'h80000000, remainder = 0.
- BUSY: one iteration per cycle, count 0 to 31, then go to FIX when count==31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring; 33-bit partial remainder, one quotient bit per cycle.
- FIX: apply two's-complement negation where required.
  - MUL*: negate the 64-bit product if the result sign is set.
  - DIV: quotient is negative iff the operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - Select the output: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits.
  - Go to DONE.
- DONE: result_valid=1 and result_rd=latched rd for exactly 1 cycle; stall=0 so ID/EX advances on this edge; next state IDLE.
  - The ID/EX register still presents the same op during DONE; DONE never re-arms, so no double issue.
- Latency, normal path: detection cycle + 32 BUSY + 1 FIX = 34 stall cycles; result_valid on cycle 35.
- Latency, special case: 1 stall cycle; result_valid on cycle 2.
- Back-to-back M ops: the second op is seen in IDLE on the cycle after DONE and starts normally.
- result and result_rd hold their last values after DONE; result_valid returns to 0.
- flush=1 in any state: next state IDLE, result_valid=0, count cleared, latched op discarded. stall is forced to 0 in the same cycle.
- flush has priority over a start in the same cycle.
- Non-M ops (m_req=0) in IDLE: no state change, stall=0, result_valid=0.
- Reset mid-operation: aborts immediately; no result_valid is produced.

Test Plan:
- MUL, A=7, B=-3 (32'hFFFFFFFD) -> stall high 34 cycles, then result_valid=1 for 1 cycle, result=32'hFFFFFFEB, result_rd=RD_EX.
- MULH, A=32'h80000000, B=32'h80000000 -> result=32'h40000000. MULHU with the same operands -> result=32'h40000000. MULHSU, A=-1, B=32'hFFFFFFFF -> result=32'hFFFFFFFF.
- DIV, A=-7, B=2 -> result=32'hFFFFFFFD. REM with the same operands -> result=32'hFFFFFFFF. DIVU, A=100, B=7 -> result=14. REMU with the same operands -> result=2.
- DIV, A=5, B=0 -> 1 stall cycle, result=32'hFFFFFFFF. REM with the same operands -> result=5. DIV, A=32'h80000000, B=-1 -> result=32'h80000000. REM with the same operands -> result=0.
- Start DIVU, assert flush at BUSY count=10 -> stall=0 that cycle, never result_valid, state IDLE. Separately, drop reset at count=20 -> all outputs 0 immediately.
- Two consecutive MULs (A=3,B=4 then A=5,B=6), ID/EX held by stall -> result_valid pulses twice, 35 cycles apart, results 12 then 30. An ADD with ALUop 10, funct7 0 -> never stalls.
